lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in data memory (power of two, 4..4096).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ALUResultM  input  32  byte address of the access.
REQ-005 WriteDataM  input  32  store data, right-aligned.
REQ-006 MemWriteM  input  1  store request this cycle.
REQ-007 MemReadM  input  1  load request this cycle.
REQ-008 Funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ReadDataM  output  32  load result, sign/zero-extended, valid in the cycle StallM is low.
REQ-010 StallM  output  1  access not complete; upstream holds EX/MEM inputs stable.
REQ-011 FaultM  output  1  one-cycle pulse: illegal Funct3M or rejected misaligned access.

Function
REQ-012 Word index SHALL be ALUResultM[log2(DEPTH)+1:2]; upper address bits ignored (wrap modulo DEPTH).
REQ-013 Aligned access (B any offset; H offset 0/2; W offset 0) SHALL complete in its presentation cycle: combinational read, write at next edge, StallM=0.
REQ-014 Stores SHALL update only the addressed bytes (byte enables); other bytes unchanged.
REQ-015 LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-016 MemWriteM and MemReadM both high: store performed, ReadDataM=0.
REQ-017 Neither request: ReadDataM=0, StallM=0, FaultM=0, no memory change.
REQ-018 Illegal Funct3M (011,110,111; 100/101 on store): no write, ReadDataM=0, FaultM=1 for that cycle.
REQ-019 FSM states IDLE and SPLIT; IDLE->SPLIT only on a misaligned access with MISALIGNED_EN defined; SPLIT->IDLE unconditionally after one cycle.
REQ-020 In SPLIT-causing cycle (IDLE): StallM=1; load captures low word into hold register; store writes low-word bytes.
REQ-021 In SPLIT: StallM=0; load merges hold register with word index+1 (wrapping DEPTH-1 -> 0) into ReadDataM; store writes remaining bytes to index+1.
REQ-022 A misaligned access therefore costs exactly 2 cycles; aligned accesses issued back-to-back sustain 1 per cycle.
REQ-023 Inputs are sampled only in IDLE for FSM decision; in SPLIT the held inputs are used as presented (upstream holds them per REQ-010).

Reset
REQ-024 reset SHALL force FSM=IDLE, hold register=0, StallM=0, FaultM=0, ReadDataM=0 in the reset cycle.
REQ-025 reset SHALL NOT clear memory contents; memory array is named dataMemory for hierarchical $readmemh preload.
REQ-026 reset asserted while in SPLIT aborts: second half of store not written, first half remains.

Configuration
REQ-027 Macro LSU_MISALIGNED_EN defined: misaligned H/W accesses split per REQ-019..021.
REQ-028 Macro undefined: misaligned H/W access performs no write, ReadDataM=0, StallM=0, FaultM=1 for one cycle; FSM never leaves IDLE.

Structure
REQ-029 Shared package holds Funct3 size/sign encodings and FSM state encoding constants.
REQ-030 One sub-module lsu_align: combinational byte-enable generation, store-data shift, load extract/extend/merge; FSM, hold register and memory remain in lsu_mem_stage.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 -> ReadDataM=0xDEADBEEF, StallM=0 both cycles.
REQ-032 SB 0x80 @0x13 over word 0x11223344; LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; word[4]=0x80223344.
REQ-033 Words[0]=0x44332211,[1]=0x88776655; LW @0x2 with LSU_MISALIGNED_EN -> StallM 1 then 0, ReadDataM=0x66554433; without macro -> FaultM=1, ReadDataM=0.
REQ-034 DEPTH=64, SW 0xAABBCCDD @0xFE with macro -> word[63][31:16]=0xCCDD, word[0][15:0]=0xAABB (wrap).
REQ-035 Misaligned SW 0xAABBCCDD @0x6 with reset asserted in SPLIT cycle -> word[1][31:16]=0xCCDD, word[2] unchanged, StallM=0 after reset.
REQ-036 Funct3M=011 with MemReadM=1 -> FaultM=1 one cycle, ReadDataM=0, no memory change.

Source files
------------

// File: rtl/lsu_mem_stage_pkg.sv
// Shared encodings for the load/store memory stage: access size/sign codes,
// FSM states and small decode helpers used by lsu_mem_stage and lsu_align.
package lsu_mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } lsuState_e;

    // Unsigned sizes only make sense for loads, so they are rejected on stores.
    function automatic logic f3Legal(input logic [2:0] f3, input logic isStore);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !isStore;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = offset[0];
            2'b10:   mis = (offset != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: combinational lane steering for the memory stage. Treats every
// access as a window over two adjacent words so aligned and split accesses share one path.
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] loWord_i,
    input  logic [31:0] hiWord_i,
    output logic [3:0]  beLo_o,
    output logic [3:0]  beHi_o,
    output logic [31:0] wdataLo_o,
    output logic [31:0] wdataHi_o,
    output logic [31:0] loadData_o
);

    logic [3:0]  sizeMask;
    logic [7:0]  beWide;
    logic [63:0] dataWide;
    logic [31:0] loadRaw;

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   sizeMask = 4'b0001;
            2'b01:   sizeMask = 4'b0011;
            2'b10:   sizeMask = 4'b1111;
            default: sizeMask = 4'b0000;
        endcase

        // Bytes that spill past lane 3 land in the following word's lanes.
        beWide   = {4'b0000, sizeMask} << offset_i;
        dataWide = {32'h0, storeData_i} << {offset_i, 3'b000};
        loadRaw  = 32'({hiWord_i, loWord_i} >> {offset_i, 3'b000});

        case (funct3_i)
            F3_B:    loadData_o = {{24{loadRaw[7]}}, loadRaw[7:0]};
            F3_H:    loadData_o = {{16{loadRaw[15]}}, loadRaw[15:0]};
            F3_W:    loadData_o = loadRaw;
            F3_BU:   loadData_o = {24'h0, loadRaw[7:0]};
            F3_HU:   loadData_o = {16'h0, loadRaw[15:0]};
            default: loadData_o = 32'h0;
        endcase
    end

    assign beLo_o    = beWide[3:0];
    assign beHi_o    = beWide[7:4];
    assign wdataLo_o = dataWide[31:0];
    assign wdataHi_o = dataWide[63:32];

endmodule

// File: rtl/lsu_mem_stage.sv
// Data-memory stage of the pipeline: byte/half/word loads and stores on a word array.
// Define LSU_MISALIGNED_EN to split misaligned H/W accesses over two cycles; otherwise they fault.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  Funct3M,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        FaultM
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] dataMemory [DEPTH];

    lsuState_e   stateQ, stateD;
    logic [31:0] holdQ, holdD;

    logic [AW-1:0] wordIdx, wordIdxNext;
    logic [1:0]    offset;
    logic          unusedAddrBits;

    logic          wrEn;
    logic [AW-1:0] wrIdx;
    logic [3:0]    wrBe;
    logic [31:0]   wrData;

    logic [31:0] alignLo;
    logic [3:0]  beLo, beHi;
    logic [31:0] wdataLo, wdataHi, loadData;

    assign wordIdx        = ALUResultM[AW+1:2];
    assign wordIdxNext    = wordIdx + AW'(1);
    assign offset         = ALUResultM[1:0];
    assign unusedAddrBits = ^ALUResultM[31:AW+2];

    // The second half of a split load merges the captured low word with the next word.
    assign alignLo = (stateQ == ST_SPLIT) ? holdQ : dataMemory[wordIdx];

    lsu_align uAlign (
        .funct3_i    (Funct3M),
        .offset_i    (offset),
        .storeData_i (WriteDataM),
        .loWord_i    (alignLo),
        .hiWord_i    (dataMemory[wordIdxNext]),
        .beLo_o      (beLo),
        .beHi_o      (beHi),
        .wdataLo_o   (wdataLo),
        .wdataHi_o   (wdataHi),
        .loadData_o  (loadData)
    );

    always_comb begin
        stateD    = ST_IDLE;
        holdD     = holdQ;
        StallM    = 1'b0;
        FaultM    = 1'b0;
        ReadDataM = 32'h0;
        wrEn      = 1'b0;
        wrIdx     = wordIdx;
        wrBe      = 4'b0000;
        wrData    = 32'h0;

        // Reset suppresses every write, which is what aborts a split store midway.
        if (!reset) begin
            case (stateQ)
                ST_IDLE: begin
                    if (MemWriteM || MemReadM) begin
                        if (!f3Legal(Funct3M, MemWriteM)) begin
                            FaultM = 1'b1;
                        end else if (isMisaligned(Funct3M, offset)) begin
`ifdef LSU_MISALIGNED_EN
                            StallM = 1'b1;
                            stateD = ST_SPLIT;
                            if (MemWriteM) begin
                                wrEn   = 1'b1;
                                wrBe   = beLo;
                                wrData = wdataLo;
                            end else begin
                                holdD = dataMemory[wordIdx];
                            end
`else
                            FaultM = 1'b1;
`endif
                        end else if (MemWriteM) begin
                            wrEn   = 1'b1;
                            wrBe   = beLo;
                            wrData = wdataLo;
                        end else begin
                            ReadDataM = loadData;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (MemWriteM) begin
                        wrEn   = 1'b1;
                        wrIdx  = wordIdxNext;
                        wrBe   = beHi;
                        wrData = wdataHi;
                    end else if (MemReadM) begin
                        ReadDataM = loadData;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= ST_IDLE;
            holdQ  <= 32'h0;
        end else begin
            stateQ <= stateD;
            holdQ  <= holdD;
        end
    end

    // Memory contents survive reset so a preload stays valid.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (wrBe[b]) begin
                    dataMemory[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage against a byte-addressed memory model.
// Follows LSU_MISALIGNED_EN the same way as the design.
module tb_lsu_mem_stage;

    localparam int DEPTH = 64;
    localparam int NB    = DEPTH * 4;
`ifdef LSU_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  Funct3M;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;

    lsu_mem_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: flat byte array, little-endian, addresses wrap modulo NB
    logic [7:0] modelMem [NB];
    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expRd;
        logic        expFault;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] savedWord;
    logic [2:0]  f3Pool [8];

    function automatic int accessSize(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit isLegal(input logic [2:0] f3, input logic isStore);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return !isStore;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic bit isAligned(input logic [31:0] addr, input logic [2:0] f3);
        int sz = accessSize(f3);
        return (sz == 0) || ((addr % 32'(sz)) == 32'h0);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] f3);
        int          sz   = accessSize(f3);
        int          base = int'(addr % 32'(NB));
        logic [31:0] v    = 32'h0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = modelMem[(base + k) % NB];
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic void modelCommit(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] data);
        int sz   = accessSize(f3);
        int base = int'(addr % 32'(NB));
        if (we && isLegal(f3, 1'b1) && (isAligned(addr, f3) || SPLIT_EN)) begin
            for (int k = 0; k < sz; k++) modelMem[(base + k) % NB] = data[8*k +: 8];
        end
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        MemWriteM  = we;
        MemReadM   = re;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = data;
    endtask

    // Samples on the falling edge, then lets the rising edge commit the cycle.
    task automatic checkOutput(input string name, input logic [31:0] expRd,
                               input logic expStall, input logic expFault, input bit chkRd);
        @(negedge clk);
        if (chkRd) compare({name, ".rd"}, ReadDataM, expRd);
        compare({name, ".stall"}, {31'h0, StallM}, {31'h0, expStall});
        compare({name, ".fault"}, {31'h0, FaultM}, {31'h0, expFault});
        @(posedge clk);
        #1;
    endtask

    task automatic runAccess(input string name, input logic we, input logic re,
                             input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        bit          req   = we || re;
        bit          legal = isLegal(f3, we);
        bit          mis   = !isAligned(addr, f3);
        bit          split = req && legal && mis && SPLIT_EN;
        bit          fault = req && (!legal || (mis && !SPLIT_EN));
        logic [31:0] expRd = 32'h0;
        if (req && legal && !fault && re && !we) expRd = modelLoad(addr, f3);
        applyStimulus(we, re, f3, addr, data);
        if (split) begin
            checkOutput({name, ".c1"}, 32'h0, 1'b1, 1'b0, 1'b0);
            checkOutput({name, ".c2"}, expRd, 1'b0, 1'b0, 1'b1);
        end else begin
            checkOutput(name, expRd, 1'b0, fault, 1'b1);
        end
        modelCommit(we, f3, addr, data);
    endtask

    initial begin
        f3Pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, W, 32'h10, 32'h0);
        checkOutput("reset_out", 32'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) runAccess("init", 1'b1, 1'b0, W, 32'(i * 4), $urandom);

        vecs.push_back('{"sw_word4",     1'b1, 1'b0, W,      32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{"lw_word4",     1'b0, 1'b1, W,      32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sw_base",      1'b1, 1'b0, W,      32'h10,       32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{"sb_80",        1'b1, 1'b0, B,      32'h13,       32'h12345680, 32'h0,        1'b0});
        vecs.push_back('{"lb_13",        1'b0, 1'b1, B,      32'h13,       32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{"lbu_13",       1'b0, 1'b1, BU,     32'h13,       32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{"lw_after_sb",  1'b0, 1'b1, W,      32'h10,       32'h0,        32'h80223344, 1'b0});
        vecs.push_back('{"lh_12",        1'b0, 1'b1, H,      32'h12,       32'h0,        32'hFFFF8022, 1'b0});
        vecs.push_back('{"lhu_12",       1'b0, 1'b1, HU,     32'h12,       32'h0,        32'h00008022, 1'b0});
        vecs.push_back('{"lw_addr_wrap", 1'b0, 1'b1, W,      32'hFFFF0010, 32'h0,        32'h80223344, 1'b0});
        vecs.push_back('{"f3_011",       1'b0, 1'b1, 3'b011, 32'h10,       32'h0,        32'h0,        1'b1});
        vecs.push_back('{"sbu_illegal",  1'b1, 1'b0, BU,     32'h10,       32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{"lw_unchanged", 1'b0, 1'b1, W,      32'h10,       32'h0,        32'h80223344, 1'b0});
        vecs.push_back('{"sw_lw_both",   1'b1, 1'b1, W,      32'h20,       32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{"lw_both_addr", 1'b0, 1'b1, W,      32'h20,       32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{"no_request",   1'b0, 1'b0, 3'b111, 32'h20,       32'h0,        32'h0,        1'b0});
        vecs.push_back('{"sw_w0",        1'b1, 1'b0, W,      32'h0,        32'h44332211, 32'h0,        1'b0});
        vecs.push_back('{"sw_w1",        1'b1, 1'b0, W,      32'h4,        32'h88776655, 32'h0,        1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].data);
            checkOutput(vecs[i].name, vecs[i].expRd, 1'b0, vecs[i].expFault, 1'b1);
            modelCommit(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].data);
        end

`ifdef LSU_MISALIGNED_EN
        applyStimulus(1'b0, 1'b1, W, 32'h2, 32'h0);
        checkOutput("mis_lw.c1", 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("mis_lw.c2", 32'h66554433, 1'b0, 1'b0, 1'b1);

        runAccess("mis_sw_wrap", 1'b1, 1'b0, W, 32'hFE, 32'hAABBCCDD);
        applyStimulus(1'b0, 1'b1, HU, 32'hFE, 32'h0);
        checkOutput("wrap_w63_hi", 32'h0000CCDD, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, HU, 32'h0, 32'h0);
        checkOutput("wrap_w0_lo", 32'h0000AABB, 1'b0, 1'b0, 1'b1);

        savedWord = modelLoad(32'h8, W);
        applyStimulus(1'b1, 1'b0, W, 32'h6, 32'hAABBCCDD);
        checkOutput("abort.c1", 32'h0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        checkOutput("abort.rst", 32'h0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        modelMem[6] = 8'hDD;
        modelMem[7] = 8'hCC;
        applyStimulus(1'b0, 1'b1, HU, 32'h6, 32'h0);
        checkOutput("abort_first_half", 32'h0000CCDD, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, W, 32'h8, 32'h0);
        checkOutput("abort_w2_kept", savedWord, 1'b0, 1'b0, 1'b1);
`else
        applyStimulus(1'b0, 1'b1, W, 32'h2, 32'h0);
        checkOutput("mis_lw_fault", 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, H, 32'h1, 32'h0);
        checkOutput("mis_lh_fault", 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, W, 32'hFE, 32'hAABBCCDD);
        checkOutput("mis_sw_fault", 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, W, 32'h0, 32'h0);
        checkOutput("w0_untouched", 32'h44332211, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            int          r    = $urandom_range(0, 9);
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            runAccess("rand", (r >= 5), (r < 4) || (r == 9),
                      f3Pool[$urandom_range(0, 7)], addr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
